// File: rtl/multicycle_cpu_if.sv
// Fetch and data-memory bus between multicycle_cpu and its external memories.
// master = CPU side, slave = memory side.
interface multicycle_cpu_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 8
);
    logic [PC_BITS-1:0]     imem_addr;
    logic                   imem_req;
    logic                   imem_valid;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [ADDR_BITS-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0]  dmem_wdata;
    logic                   dmem_wen;
    logic [DATA_WIDTH-1:0]  dmem_rdata;

    modport master (
        output imem_addr, imem_req,
        output dmem_addr, dmem_wdata, dmem_wen,
        input  imem_valid, instruction, dmem_rdata
    );

    modport slave (
        input  imem_addr, imem_req,
        input  dmem_addr, dmem_wdata, dmem_wen,
        output imem_valid, instruction, dmem_rdata
    );
endinterface

// File: rtl/multicycle_cpu.sv
// Self-fetching multicycle CPU: FETCH/DECODE/EXEC/(MEM/MEMWAIT)/WB sequencer.
// Define CPU_MUL_EN to turn opcode 11 into MUL; otherwise it is a NOP.
module multicycle_cpu #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 8
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_cpu_if.master   bus,
    output logic               retire,
    output logic               halted
);
    localparam int IMM_W = INSTR_WIDTH - 4 - 2 * ADDR_BITS;
    localparam int NREG  = 2 ** ADDR_BITS;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;
`ifdef CPU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
`endif

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        MEMWAIT,
        WB,
        HALTED
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0]  opa_q, opa_d;
    logic [DATA_WIDTH-1:0]  opb_q, opb_d;
    logic [DATA_WIDTH-1:0]  opd_q, opd_d;
    logic [DATA_WIDTH-1:0]  res_q, res_d;
    logic [DATA_WIDTH-1:0]  regs_q [NREG];

    logic [3:0]            op;
    logic [ADDR_BITS-1:0]  rd, rs1, rs2;
    logic [IMM_W-1:0]      imm;
    logic [DATA_WIDTH-1:0] simm;
    logic [DATA_WIDTH-1:0] addr_sum;
    logic [DATA_WIDTH-1:0] alu;
    logic                  wr_rd;
    logic                  rf_we;
    logic                  is_ld, is_st, is_beq, is_jmp, is_halt;

    assign op   = instr_q[INSTR_WIDTH-1 -: 4];
    assign rd   = instr_q[INSTR_WIDTH-5 -: ADDR_BITS];
    assign rs1  = instr_q[INSTR_WIDTH-5-ADDR_BITS -: ADDR_BITS];
    assign imm  = instr_q[IMM_W-1:0];
    assign rs2  = imm[IMM_W-1 -: ADDR_BITS];
    assign simm = DATA_WIDTH'($signed(imm));

    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign is_beq  = (op == OP_BEQ);
    assign is_jmp  = (op == OP_JMP);
    assign is_halt = (op == OP_HALT);

    // Operands stay latched until the next DECODE, so the address is stable through MEMWAIT.
    assign addr_sum = opa_q + simm;

    function automatic logic [DATA_WIDTH-1:0] rf_rd(input logic [ADDR_BITS-1:0] idx);
        return (idx == '0) ? '0 : regs_q[idx];
    endfunction

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = opa_q + opb_q;
            OP_SUB:  alu = opa_q - opb_q;
            OP_AND:  alu = opa_q & opb_q;
            OP_OR:   alu = opa_q | opb_q;
            OP_XOR:  alu = opa_q ^ opb_q;
            OP_ADDI: alu = addr_sum;
            OP_LD:   alu = addr_sum;
            OP_ST:   alu = addr_sum;
`ifdef CPU_MUL_EN
            OP_MUL:  alu = opa_q * opb_q;
`endif
            default: alu = '0;
        endcase
    end

    always_comb begin
        wr_rd = (op <= OP_LD);
`ifdef CPU_MUL_EN
        if (op == OP_MUL) wr_rd = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opd_d   = opd_q;
        res_d   = res_q;
        rf_we   = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.imem_valid) begin
                    instr_d = bus.instruction;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                opa_d   = rf_rd(rs1);
                opb_d   = rf_rd(rs2);
                opd_d   = rf_rd(rd);
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu;
                state_d = is_ld ? MEM : WB;
            end
            MEM: state_d = MEMWAIT;
            MEMWAIT: begin
                res_d   = bus.dmem_rdata;
                state_d = WB;
            end
            WB: begin
                rf_we = wr_rd && (rd != '0);
                unique case (1'b1)
                    is_beq: begin
                        if (opd_q == opa_q)
                            pc_d = pc_q + PC_BITS'(1) + PC_BITS'($signed(imm));
                        else
                            pc_d = pc_q + PC_BITS'(1);
                    end
                    is_jmp:  pc_d = PC_BITS'(imm);
                    default: pc_d = pc_q + PC_BITS'(1);
                endcase
                state_d = is_halt ? HALTED : FETCH;
            end
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            opd_q   <= '0;
            res_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opd_q   <= opd_d;
            res_q   <= res_d;
            if (rf_we) regs_q[rd] <= res_q;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.imem_req   = (state_q == FETCH);
    assign bus.dmem_addr  = addr_sum[ADDR_BITS-1:0];
    assign bus.dmem_wdata = opd_q;
    // A store caught by reset in EXEC must not reach memory.
    assign bus.dmem_wen   = (state_q == EXEC) && is_st && !rst;
    assign retire         = (state_q == WB);
    assign halted         = (state_q == HALTED);
endmodule
